seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter CLKS_PER_DIGIT, default 25000, lit-time per digit slot in clocks (1 ms at 25 MHz); SHALL be >= 1.
REQ-002 Parameter GUARD_CLKS, default 16, all-digits-off dead time before each digit slot in clocks; SHALL be >= 2.
REQ-003 i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_enable  input  1  1 = scan running, 0 = all digits off.
REQ-006 i_value  input  16  four hex nibbles; nibble k drives digit k, digit 0 = i_value[3:0].
REQ-007 i_load  input  1  single-cycle strobe capturing i_value into the pending register.
REQ-008 i_lz_blank  input  1  1 = suppress leading zeros.
REQ-009 o_segments  output  7  bit0=A .. bit6=G, active-high (1 = lit); top level performs any polarity inversion.
REQ-010 o_digit_en  output  4  one-hot digit enable, active-high; 4'b0000 = all off.
REQ-011 o_frame_done  output  1  one-cycle pulse at the end of the digit-3 slot.

Function
REQ-012 The block SHALL time-multiplex one shared decoder instance across 4 digits in order 0,1,2,3,0,...
REQ-013 FSM states SHALL be IDLE, GUARD and SHOW, with a 2-bit digit index and a refresh counter sized for max(CLKS_PER_DIGIT, GUARD_CLKS).
REQ-014 IDLE -> GUARD(digit 0) SHALL occur on the cycle after i_enable is sampled 1.
REQ-015 GUARD SHALL last exactly GUARD_CLKS cycles with o_digit_en=0, presenting the nibble for the current digit to the decoder so its 1-cycle latency is absorbed.
REQ-016 GUARD -> SHOW SHALL occur after GUARD_CLKS cycles; SHOW lasts exactly CLKS_PER_DIGIT cycles with o_digit_en = one-hot(index), unless the digit is blanked.
REQ-017 On SHOW expiry the index SHALL increment (3 wraps to 0) and the FSM enters GUARD; one slot = GUARD_CLKS + CLKS_PER_DIGIT, one frame = 4 slots.
REQ-018 o_frame_done SHALL pulse high for 1 cycle on the last SHOW cycle of digit 3.
REQ-019 With i_lz_blank=1, digit k (k = 1..3) SHALL be blanked (o_digit_en=0 for its whole slot, timing unchanged) when active nibbles k..3 are all zero; digit 0 SHALL never be blanked.
REQ-020 On i_load, i_value SHALL be written to the pending register and the pending flag set; the last load before a frame start wins.
REQ-021 At frame start (entry to GUARD for digit 0), if the pending flag is set, the active register SHALL take the pending value and the flag SHALL clear; a load in that same cycle SHALL pass i_value directly to the active register.
REQ-022 The active value SHALL never change mid-frame (no tearing).
REQ-023 o_segments SHALL be forced to 7'b0 whenever o_digit_en = 0.
REQ-024 If i_enable is sampled 0 in any state, the FSM SHALL enter IDLE the next cycle with o_digit_en=0 and no o_frame_done; re-enable SHALL restart at GUARD(digit 0).
REQ-025 o_digit_en and o_frame_done SHALL be registered outputs.

Reset
REQ-026 While i_rst=1, the block SHALL set state=IDLE, index=0, counter=0, active and pending=16'h0000, pending flag=0, o_digit_en=0, o_frame_done=0, and o_segments=0.
REQ-027 Reset asserted mid-operation SHALL take effect on the next clock edge and override i_load and i_enable.

Structure
REQ-028 The shared package SHALL hold NUM_DIGITS=4, the FSM state encodings and the segment bit-position constants.
REQ-029 The block SHALL contain exactly one sub-module: Seven_Segment_Decoder (4-bit in, 7 registered segment outputs), instantiated once.

Verification (CLKS_PER_DIGIT=4, GUARD_CLKS=2)
REQ-030 Reset, load 16'h12AF, enable -> slots of 4 cycles separated by 2-cycle gaps: en=0001 seg=7'h71, en=0010 seg=7'h77, en=0100 seg=7'h5B, en=1000 seg=7'h06, then o_frame_done for 1 cycle; period 24 cycles.
REQ-031 i_lz_blank=1, load 16'h0005 -> only en=0001 with seg=7'h6D, en=0 in slots 1-3; load 16'h0000 -> digit 0 shows 7'h3F.
REQ-032 Load 16'h1111 before frame start, then load 16'h2222 during digit 2 -> current frame shows all 7'h06; next frame shows all 7'h5B.
REQ-033 Deassert i_enable during SHOW of digit 1 -> en=0000 and seg=0 on the next cycle, no frame_done; re-enable -> first lit slot is digit 0 after 2 guard cycles.
REQ-034 Assert i_rst mid-SHOW with a simultaneous i_load -> all outputs 0 on the next cycle; after re-enable, digit 0 shows 7'h3F.
REQ-035 Pulse i_load with 16'hBEEF in the frame-start cycle -> that frame shows F, E, E, B (7'h71, 7'h79, 7'h79, 7'h7C).

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | seven_segment_scanner_pkg : shared digit count, FSM encodings, segment bits
// | Rev 1.0
// +-----------------------------------------------------------------------------
package seven_segment_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // A digit above 0 is a leading zero when it and every digit above it are zero.
  function automatic logic isBlanked(input logic [1:0] index, input logic [15:0] value,
                                     input logic lzBlank);
    logic [15:0] upper;
    upper = value >> {index, 2'b00};
    return lzBlank && (index != 2'd0) && (upper == 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/Seven_Segment_Decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Seven_Segment_Decoder : hex nibble to active-high segments, one clock latency
// | Rev 1.0
// +-----------------------------------------------------------------------------
module Seven_Segment_Decoder
  import seven_segment_scanner_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  logic [6:0] w_pattern;

  always_comb begin
    w_pattern = 7'h00;
    case (i_nibble)
      4'h0: w_pattern = 7'h3F;
      4'h1: w_pattern = 7'h06;
      4'h2: w_pattern = 7'h5B;
      4'h3: w_pattern = 7'h4F;
      4'h4: w_pattern = 7'h66;
      4'h5: w_pattern = 7'h6D;
      4'h6: w_pattern = 7'h7D;
      4'h7: w_pattern = 7'h07;
      4'h8: w_pattern = 7'h7F;
      4'h9: w_pattern = 7'h6F;
      4'hA: w_pattern = 7'h77;
      4'hB: w_pattern = 7'h7C;
      4'hC: w_pattern = 7'h39;
      4'hD: w_pattern = 7'h5E;
      4'hE: w_pattern = 7'h79;
      4'hF: w_pattern = 7'h71;
      default: w_pattern = 7'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_segments <= 7'h00;
    end else begin
      o_segments[SEG_A] <= w_pattern[0];
      o_segments[SEG_B] <= w_pattern[1];
      o_segments[SEG_C] <= w_pattern[2];
      o_segments[SEG_D] <= w_pattern[3];
      o_segments[SEG_E] <= w_pattern[4];
      o_segments[SEG_F] <= w_pattern[5];
      o_segments[SEG_G] <= w_pattern[6];
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | seven_segment_scanner : 4-digit multiplexed display scanner with guard time
// | Rev 1.0
// +-----------------------------------------------------------------------------
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int GUARD_CLKS     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic        i_lz_blank,
  output logic [6:0]  o_segments,
  output logic [3:0]  o_digit_en,
  output logic        o_frame_done
);

  localparam int MAX_CLKS = (CLKS_PER_DIGIT > GUARD_CLKS) ? CLKS_PER_DIGIT : GUARD_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS + 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CLKS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] SHOW_PRELAST = CNT_W'(CLKS_PER_DIGIT - 2);
  localparam logic [1:0]       LAST_DIGIT   = 2'(NUM_DIGITS - 1);

  state_t           r_state;
  logic [1:0]       r_index;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_active;
  logic [15:0]      r_pending;
  logic             r_pendValid;
  logic [3:0]       r_digitEn;
  logic             r_frameDone;

  logic             w_frameStart;
  logic [3:0]       w_nibble;
  logic [6:0]       w_decSeg;

  // Frame start is every entry into GUARD for digit 0.
  assign w_frameStart = i_enable &&
                        ((r_state == ST_IDLE) ||
                         (r_state == ST_SHOW && r_count == SHOW_LAST && r_index == LAST_DIGIT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active    <= 16'h0000;
      r_pending   <= 16'h0000;
      r_pendValid <= 1'b0;
    end else if (w_frameStart) begin
      if (i_load) begin
        r_active  <= i_value;
        r_pending <= i_value;
      end else if (r_pendValid) begin
        r_active  <= r_pending;
      end
      r_pendValid <= 1'b0;
    end else if (i_load) begin
      r_pending   <= i_value;
      r_pendValid <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_index     <= 2'd0;
      r_count     <= '0;
      r_digitEn   <= 4'b0000;
      r_frameDone <= 1'b0;
    end else if (!i_enable) begin
      r_state     <= ST_IDLE;
      r_index     <= 2'd0;
      r_count     <= '0;
      r_digitEn   <= 4'b0000;
      r_frameDone <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_GUARD;
          r_index <= 2'd0;
          r_count <= '0;
        end
        ST_GUARD: begin
          if (r_count == GUARD_LAST) begin
            r_state     <= ST_SHOW;
            r_count     <= '0;
            r_digitEn   <= isBlanked(r_index, r_active, i_lz_blank) ? 4'b0000
                                                                   : (4'b0001 << r_index);
            r_frameDone <= (r_index == LAST_DIGIT) && (CLKS_PER_DIGIT == 1);
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_SHOW: begin
          if (r_count == SHOW_LAST) begin
            r_state     <= ST_GUARD;
            r_count     <= '0;
            r_index     <= r_index + 1'b1;
            r_digitEn   <= 4'b0000;
            r_frameDone <= 1'b0;
          end else begin
            r_count     <= r_count + 1'b1;
            r_frameDone <= (CLKS_PER_DIGIT >= 2) && (r_index == LAST_DIGIT) &&
                           (r_count == SHOW_PRELAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The decoder sees the current digit's nibble throughout GUARD, hiding its latency.
  assign w_nibble = r_active[{r_index, 2'b00} +: 4];

  Seven_Segment_Decoder u_decoder (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_nibble   (w_nibble),
    .o_segments (w_decSeg)
  );

  assign o_segments   = (r_digitEn != 4'b0000) ? w_decSeg : 7'h00;
  assign o_digit_en   = r_digitEn;
  assign o_frame_done = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_seven_segment_scanner : scoreboard bench, per-cycle expected output trace
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int CPD = 4;
  localparam int GC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic        lz;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  en;
  logic        fd;

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       fd;
  } obs_t;

  obs_t sb[$];
  obs_t obs[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(.CLKS_PER_DIGIT(CPD), .GUARD_CLKS(GC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_value      (value),
    .i_load       (load),
    .i_lz_blank   (lz),
    .o_segments   (seg),
    .o_digit_en   (en),
    .o_frame_done (fd)
  );

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame of expected per-cycle outputs, starting with the cycle after frame start.
  task automatic push_frame(input logic [15:0] v, input logic lzb);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] upper;
      logic        blank;
      obs_t        e;
      upper = v >> (4 * k);
      blank = lzb && (k != 0) && (upper == 16'h0000);
      for (int g = 0; g < GC; g++) sb.push_back('0);
      for (int j = 0; j < CPD; j++) begin
        e.en  = blank ? 4'b0000 : 4'(1 << k);
        e.seg = blank ? 7'h00 : segOf(v[4*k +: 4]);
        e.fd  = (k == 3) && (j == CPD - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input int loadAt, input logic [15:0] loadVal);
    for (int i = 0; i < n; i++) begin
      if (i == loadAt) begin
        load  = 1'b1;
        value = loadVal;
      end
      step();
      load = 1'b0;
      obs.push_back({en, seg, fd});
    end
  endtask

  task automatic restart(input logic [15:0] v);
    sb.delete();
    obs.delete();
    enable = 1'b0;
    step();
    load  = 1'b1;
    value = v;
    step();
    load   = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b1; value = 16'hFFFF; lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      nCompared++;
      if ({en, seg, fd} !== 12'h000) begin
        nMismatched++;
        $display("FAIL reset[%0d]: got {en,seg,fd}=%03h want 000", i, {en, seg, fd});
      end
    end
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    step();
    nCompared++;
    if ({en, seg, fd} !== 12'h000) begin
      nMismatched++;
      $display("FAIL reset_idle: got {en,seg,fd}=%03h want 000", {en, seg, fd});
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    lz = 1'b0;
    restart(16'h12AF);
    push_frame(16'h12AF, 1'b0);
    push_frame(16'h12AF, 1'b0);
    run(48, -1, 16'h0);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL basic[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
  endtask

  task automatic test_lz_blank();
    obs_t e, o;
    lz = 1'b1;
    restart(16'h0005);
    push_frame(16'h0005, 1'b1);
    push_frame(16'h0000, 1'b1);
    run(48, 5, 16'h0000);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL lz_blank[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_no_tearing();
    obs_t e, o;
    restart(16'h1111);
    push_frame(16'h1111, 1'b0);
    push_frame(16'h2222, 1'b0);
    run(48, 14, 16'h2222);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL no_tearing[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
  endtask

  task automatic test_frame_start_load();
    obs_t e, o;
    restart(16'h0000);
    push_frame(16'h0000, 1'b0);
    push_frame(16'hBEEF, 1'b0);
    run(48, 24, 16'hBEEF);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL frame_start_load[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
  endtask

  task automatic test_disable();
    obs_t e, o;
    restart(16'h12AF);
    push_frame(16'h12AF, 1'b0);
    run(10, -1, 16'h0);
    for (int i = 0; i < 10; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL disable_pre[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
    sb.delete();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      nCompared++;
      if ({en, seg, fd} !== 12'h000) begin
        nMismatched++;
        $display("FAIL disable_off[%0d]: got {en,seg,fd}=%03h want 000", i, {en, seg, fd});
      end
    end
    enable = 1'b1;
    push_frame(16'h12AF, 1'b0);
    run(24, -1, 16'h0);
    for (int i = 0; i < 24; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL disable_reenable[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    restart(16'h12AF);
    push_frame(16'h12AF, 1'b0);
    run(9, -1, 16'h0);
    for (int i = 0; i < 9; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL reset_mid_pre[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
    sb.delete();
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    nCompared++;
    if ({en, seg, fd} !== 12'h000) begin
      nMismatched++;
      $display("FAIL reset_mid: got {en,seg,fd}=%03h want 000", {en, seg, fd});
    end
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    step();
    enable = 1'b1;
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b0);
    run(48, -1, 16'h0);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); nCompared++;
      if (o !== e) begin
        nMismatched++;
        $display("FAIL reset_mid_after[%0d]: got {en,seg,fd}=%03h want %03h", i, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; lz = 1'b0; value = 16'h0000;
    test_reset();
    test_basic();
    test_lz_blank();
    test_no_tearing();
    test_frame_start_load();
    test_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
